// File: rtl/game_control_fsm_if.sv
// Handshake bundle between the game control FSM and the plotting datapath / detectors.
interface game_control_fsm_if #(
  parameter int LIFE_W  = 4,
  parameter int LEVEL_W = 2
);
  logic               start;
  logic               collide;
  logic               reached_end;
  logic               plot_done;
  logic               writeEnable;
  logic               draw;
  logic               erase;
  logic               update;
  logic               respawn;
  logic               game_over;
  logic               win;
  logic [LIFE_W-1:0]  lives;
  logic [LEVEL_W-1:0] level;

  modport master (
    input  start, collide, reached_end, plot_done,
    output writeEnable, draw, erase, update, respawn, game_over, win, lives, level
  );

  modport slave (
    output start, collide, reached_end, plot_done,
    input  writeEnable, draw, erase, update, respawn, game_over, win, lives, level
  );
endinterface

// File: rtl/game_control_fsm.sv
// Frame-paced draw/erase/update sequencer for the player object, with lives,
// level progression and terminal win / game-over states.
module game_control_fsm #(
  parameter int LIVES       = 3,
  parameter int LIFE_W      = 4,
  parameter int LEVELS      = 4,
  parameter int LEVEL_W     = 2,
  parameter int FRAME_TICKS = 833334,
  parameter int CNT_W       = 20,
  parameter int HIT_HOLD    = 30
) (
  input  logic                clock,
  input  logic                reset,
  game_control_fsm_if.master  bus
);
  localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DRAW, S_WAIT, S_ERASE, S_UPDATE,
    S_CHECK, S_HIT, S_RESPAWN, S_OVER, S_WIN
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    frame_cnt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [LIFE_W-1:0]   lives, lives_nxt;
  logic [LEVEL_W-1:0]  level, level_nxt;
  logic                frame_tick;

  assign frame_tick = (frame_cnt == CNT_W'(FRAME_TICKS-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      lives     <= LIFE_W'(LIVES);
      level     <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_tick ? '0 : frame_cnt + CNT_W'(1);
      hold_cnt  <= hold_nxt;
      lives     <= lives_nxt;
      level     <= level_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    hold_nxt        = hold_cnt;
    lives_nxt       = lives;
    level_nxt       = level;
    bus.writeEnable = 1'b0;
    bus.draw        = 1'b0;
    bus.erase       = 1'b0;
    bus.update      = 1'b0;
    bus.respawn     = 1'b0;
    bus.game_over   = 1'b0;
    bus.win         = 1'b0;
    case (state)
      S_IDLE: begin
        bus.writeEnable = 1'b1;
        bus.draw        = 1'b1;
        if (bus.start) state_nxt = S_LOAD;
      end
      S_LOAD:   if (!bus.start) state_nxt = S_DRAW;
      S_DRAW: begin
        bus.writeEnable = 1'b1;
        bus.draw        = 1'b1;
        if (bus.plot_done) state_nxt = S_WAIT;
      end
      S_WAIT:   if (frame_tick) state_nxt = S_ERASE;
      S_ERASE: begin
        bus.writeEnable = 1'b1;
        bus.erase       = 1'b1;
        if (bus.plot_done) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        bus.update = 1'b1;
        state_nxt  = S_CHECK;
      end
      // Collision outranks goal, so a simultaneous hit never advances the level.
      S_CHECK: begin
        if (bus.collide) begin
          if (lives > LIFE_W'(1)) begin
            lives_nxt = lives - LIFE_W'(1);
            hold_nxt  = '0;
            state_nxt = S_HIT;
          end else begin
            lives_nxt = '0;
            state_nxt = S_OVER;
          end
        end else if (bus.reached_end) begin
          if (level == LEVEL_W'(LEVELS-1)) begin
            state_nxt = S_WIN;
          end else begin
            level_nxt = level + LEVEL_W'(1);
            state_nxt = S_RESPAWN;
          end
        end else begin
          state_nxt = S_DRAW;
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          if (hold_cnt == HOLD_W'(HIT_HOLD-1)) state_nxt = S_RESPAWN;
          else                                 hold_nxt  = hold_cnt + HOLD_W'(1);
        end
      end
      S_RESPAWN: begin
        bus.respawn = 1'b1;
        state_nxt   = S_DRAW;
      end
      S_OVER:   bus.game_over = 1'b1;
      S_WIN: begin
        bus.win         = 1'b1;
        bus.writeEnable = 1'b1;
        bus.draw        = 1'b1;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.lives = lives;
  assign bus.level = level;
endmodule

// File: tb/tb_game_control_fsm.sv
// Self-checking bench: cycle-exact vector table plus hand-written corner sequences.
module tb_game_control_fsm;
  // outs = {writeEnable, draw, erase, update, respawn, game_over, win}
  localparam logic [6:0] P_IDLE  = 7'b1100000;
  localparam logic [6:0] P_LOAD  = 7'b0000000;
  localparam logic [6:0] P_DRAW  = 7'b1100000;
  localparam logic [6:0] P_WAIT  = 7'b0000000;
  localparam logic [6:0] P_ERASE = 7'b1010000;
  localparam logic [6:0] P_UPD   = 7'b0001000;
  localparam logic [6:0] P_CHK   = 7'b0000000;
  localparam logic [6:0] P_HIT   = 7'b0000000;
  localparam logic [6:0] P_RSP   = 7'b0000100;
  localparam logic [6:0] P_OVER  = 7'b0000010;
  localparam logic [6:0] P_WIN   = 7'b1100001;

  // in = {reset, start, collide, reached_end, plot_done}
  typedef struct {
    logic [4:0] in;
    logic [6:0] outs;
    logic [3:0] lives;
    logic [1:0] level;
    string      name;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[27];

  game_control_fsm_if #(.LIFE_W(4), .LEVEL_W(2)) bus();

  game_control_fsm #(
    .LIVES(2), .LIFE_W(4), .LEVELS(2), .LEVEL_W(2),
    .FRAME_TICKS(4), .CNT_W(2), .HIT_HOLD(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] outs_now();
    return {bus.writeEnable, bus.draw, bus.erase, bus.update, bus.respawn, bus.game_over, bus.win};
  endfunction

  function automatic vec_t mk(logic [4:0] in, logic [6:0] o, logic [3:0] lv, logic [1:0] lvl, string nm);
    vec_t v;
    v.in = in; v.outs = o; v.lives = lv; v.level = lvl; v.name = nm;
    return v;
  endfunction

  task automatic drive(input logic [4:0] in);
    {reset, bus.start, bus.collide, bus.reached_end, bus.plot_done} = in;
  endtask

  task automatic step(input logic [4:0] in, input logic [6:0] o, input logic [3:0] lv,
                      input logic [1:0] lvl, input string nm);
    vec_t e;
    drive(in);
    sb.push_back(mk(in, o, lv, lvl, nm));
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++;
    if (outs_now() !== e.outs || bus.lives !== e.lives || bus.level !== e.level) begin
      errors++;
      $display("FAIL %s: outs=%b lives=%0d level=%0d, required outs=%b lives=%0d level=%0d",
               e.name, outs_now(), bus.lives, bus.level, e.outs, e.lives, e.level);
    end
  endtask

  task automatic wait_out(input logic [6:0] o, input int budget, input string nm);
    bit hit = 0;
    drive(5'b00000);
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clock); #1;
      if (outs_now() === o) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: outs=%b after %0d cycles, required %b", nm, outs_now(), budget, o);
    end
  endtask

  // From S_DRAW, run one frame to S_CHECK.
  task automatic to_check(input logic [3:0] lv, input logic [1:0] lvl);
    step(5'b00001, P_WAIT, lv, lvl, "draw_done");
    wait_out(P_ERASE, 8, "reach_erase");
    step(5'b00001, P_UPD, lv, lvl, "update_pulse");
    step(5'b00000, P_CHK, lv, lvl, "check");
  endtask

  initial begin
    drive(5'b10000);
    #2;
    tbl[0]  = mk(5'b10000, P_IDLE,  2, 0, "reset0");
    tbl[1]  = mk(5'b10000, P_IDLE,  2, 0, "reset1");
    tbl[2]  = mk(5'b01000, P_LOAD,  2, 0, "load0");
    tbl[3]  = mk(5'b01000, P_LOAD,  2, 0, "load1");
    tbl[4]  = mk(5'b01000, P_LOAD,  2, 0, "load2");
    tbl[5]  = mk(5'b00000, P_DRAW,  2, 0, "first_draw");
    tbl[6]  = mk(5'b00001, P_WAIT,  2, 0, "wait0");
    tbl[7]  = mk(5'b00001, P_WAIT,  2, 0, "wait_pd_ignored");
    tbl[8]  = mk(5'b00110, P_WAIT,  2, 0, "wait_col_ignored");
    tbl[9]  = mk(5'b00000, P_ERASE, 2, 0, "erase_on_tick");
    tbl[10] = mk(5'b00001, P_UPD,   2, 0, "update1");
    tbl[11] = mk(5'b00000, P_CHK,   2, 0, "check1");
    tbl[12] = mk(5'b00000, P_DRAW,  2, 0, "redraw");
    tbl[13] = mk(5'b00001, P_WAIT,  2, 0, "wait1_0");
    tbl[14] = mk(5'b00000, P_WAIT,  2, 0, "wait1_1");
    tbl[15] = mk(5'b00000, P_WAIT,  2, 0, "wait1_2");
    tbl[16] = mk(5'b00000, P_WAIT,  2, 0, "wait1_3");
    tbl[17] = mk(5'b00000, P_ERASE, 2, 0, "erase2");
    tbl[18] = mk(5'b00001, P_UPD,   2, 0, "update2");
    tbl[19] = mk(5'b00000, P_CHK,   2, 0, "check2");
    tbl[20] = mk(5'b00100, P_HIT,   1, 0, "hit_enter");
    tbl[21] = mk(5'b00001, P_HIT,   1, 0, "hit_hold0");
    tbl[22] = mk(5'b00010, P_HIT,   1, 0, "hit_hold1");
    tbl[23] = mk(5'b00000, P_HIT,   1, 0, "hit_hold2");
    tbl[24] = mk(5'b00000, P_HIT,   1, 0, "hit_hold3");
    tbl[25] = mk(5'b00000, P_RSP,   1, 0, "respawn_pulse");
    tbl[26] = mk(5'b00000, P_DRAW,  1, 0, "draw_after_hit");
    for (int i = 0; i < 27; i++)
      step(tbl[i].in, tbl[i].outs, tbl[i].lives, tbl[i].level, tbl[i].name);

    // Last life lost: terminal game over, start ignored.
    to_check(1, 0);
    step(5'b00100, P_OVER, 0, 0, "game_over");
    for (int i = 0; i < 20; i++)
      step({1'b0, i[0], 3'b000}, P_OVER, 0, 0, "over_hold");
    step(5'b10000, P_IDLE, 2, 0, "reset_from_over");

    // Level advance then win.
    step(5'b01000, P_LOAD, 2, 0, "b_load");
    step(5'b00000, P_DRAW, 2, 0, "b_draw");
    to_check(2, 0);
    step(5'b00010, P_RSP,  2, 1, "level_up");
    step(5'b00000, P_DRAW, 2, 1, "level_draw");
    to_check(2, 1);
    step(5'b00010, P_WIN,  2, 1, "win");
    step(5'b01000, P_WIN,  2, 1, "win_hold_start");
    step(5'b00010, P_WIN,  2, 1, "win_hold_end");
    step(5'b10000, P_IDLE, 2, 0, "reset_from_win");

    // Collide and goal together, then reset mid-hold.
    step(5'b01000, P_LOAD, 2, 0, "c_load");
    step(5'b00000, P_DRAW, 2, 0, "c_draw");
    to_check(2, 0);
    step(5'b00110, P_HIT,  1, 0, "priority_collide");
    step(5'b00000, P_HIT,  1, 0, "priority_hold");
    step(5'b10000, P_IDLE, 2, 0, "reset_in_hit");
    step(5'b00000, P_IDLE, 2, 0, "idle_after_hit_reset");

    // Reset mid-erase.
    step(5'b01000, P_LOAD, 2, 0, "d_load");
    step(5'b00000, P_DRAW, 2, 0, "d_draw");
    step(5'b00001, P_WAIT, 2, 0, "d_wait");
    wait_out(P_ERASE, 8, "d_reach_erase");
    step(5'b10001, P_IDLE, 2, 0, "reset_in_erase");
    step(5'b00000, P_IDLE, 2, 0, "idle_after_erase_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_control_fsm.md
Name: game_control_fsm

Overview:
- Parametrised successor to the obstacle-dodger control FSM.
- Sequences frame-paced draw / erase / update cycles for the player object.
- Tracks lives and level progression, and reports win or game-over.
- Sits between the start key, the collision/end detectors and the plotting datapath; it drives that datapath's write-enable, colour-select and move/respawn strobes.

Parameters:
- LIVES, 3: starting lives, 1..15.
- LIFE_W, 4: width of the lives output.
- LEVELS, 4: number of levels, >=1; clearing level LEVELS-1 wins.
- LEVEL_W, 2: width of the level output, must hold LEVELS-1.
- FRAME_TICKS, 833334: clocks per frame (60 Hz at 50 MHz), >=2.
- CNT_W, 20: frame counter width, must hold FRAME_TICKS-1.
- HIT_HOLD, 30: frames frozen after a collision before respawn, >=1.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces S_IDLE
- start  in  1  start key, level-sensitive
- collide  in  1  object overlaps obstacle; sampled only in S_CHECK
- reached_end  in  1  object at goal; sampled only in S_CHECK
- plot_done  in  1  datapath finished current draw/erase sweep; sampled only in S_DRAW/S_ERASE
- writeEnable  out  1  VGA memory write enable
- draw  out  1  1 = object colour, 0 = background
- erase  out  1  high during erase sweep
- update  out  1  one-cycle pulse: datapath advances object position
- respawn  out  1  one-cycle pulse: datapath reloads start position
- lives  out  LIFE_W  remaining lives
- level  out  LEVEL_W  current level, 0-based
- game_over  out  1  high in S_OVER
- win  out  1  high in S_WIN

Behaviour:
- Outputs are a Moore decode of the registered state. lives and level are registers.
- Reset (on a clock edge with reset=1): state=S_IDLE, frame_cnt=0, hold_cnt=0, lives=LIVES, level=0.
- Outputs after reset: writeEnable=1, draw=1; all other outputs 0.
- Reset overrides every state and every input, including mid-sweep and terminal states.
- Frame counter:
  - Free-runs 0..FRAME_TICKS-1 and wraps, in all states.
  - Internal frame_tick=1 when frame_cnt==FRAME_TICKS-1.
- States and transitions (outputs not listed are 0):
  - S_IDLE: writeEnable=1, draw=1. start=1 -> S_LOAD.
  - S_LOAD: stay while start=1; start=0 -> S_DRAW.
  - S_DRAW: writeEnable=1, draw=1. plot_done=1 -> S_WAIT.
  - S_WAIT: frame_tick=1 -> S_ERASE.
  - S_ERASE: writeEnable=1, erase=1, draw=0. plot_done=1 -> S_UPDATE.
  - S_UPDATE: update=1 for exactly one cycle -> S_CHECK.
  - S_CHECK: one cycle, lets the datapath register the new position. Priority collide > reached_end > neither.
    - collide=1, lives>1: lives<=lives-1, hold_cnt<=0 -> S_HIT.
    - collide=1, lives==1: lives<=0 -> S_OVER.
    - reached_end=1, level==LEVELS-1: -> S_WIN.
    - reached_end=1, otherwise: level<=level+1 -> S_RESPAWN.
    - neither: -> S_DRAW.
  - S_HIT: object frozen, no writes. On each frame_tick, hold_cnt increments. A frame_tick with hold_cnt==HIT_HOLD-1 -> S_RESPAWN.
  - S_RESPAWN: respawn=1 for one cycle -> S_DRAW.
  - S_OVER: game_over=1. Terminal until reset; start is ignored.
  - S_WIN: win=1, writeEnable=1, draw=1. Terminal until reset.
- Latency:
  - Start release to first write: 1 cycle (S_LOAD -> S_DRAW).
  - Collision to respawn pulse: HIT_HOLD frame ticks plus 1 cycle.
- Ignored inputs: plot_done outside S_DRAW/S_ERASE; collide/reached_end outside S_CHECK.
- Simultaneous collide and reached_end in S_CHECK: collision wins, level unchanged.
- lives never underflows and never increments. level never exceeds LEVELS-1.
- Unused state encodings recover to S_IDLE on the next edge.

Test Plan:
All scenarios use LIVES=2, LEVELS=2, FRAME_TICKS=4, HIT_HOLD=2.
- Reset/start:
  - reset=1 for 2 cycles -> writeEnable=1, draw=1, lives=2, level=0.
  - Then start=1 for 3 cycles, then start=0 -> first cycle after release is S_DRAW (writeEnable=1, draw=1).
- Frame loop:
  - plot_done pulse in S_DRAW -> outputs idle until frame_tick.
  - Then erase=1, draw=0; after plot_done, exactly one update pulse.
  - With collide=0, reached_end=0, the next state is S_DRAW. Period between update pulses is >=4 clocks and aligned to frame_tick.
- Collision:
  - collide=1 held during S_CHECK -> lives=1.
  - No writeEnable for 2 frame ticks, then a single respawn pulse, then S_DRAW.
  - A second collision -> lives=0, game_over=1, stays 1 with start toggled for 20 cycles.
- Level/win:
  - reached_end=1 in S_CHECK -> level=1, respawn pulse.
  - reached_end=1 again -> win=1, writeEnable=1, draw=1, level stays 1.
- Priority:
  - collide=1 and reached_end=1 in the same S_CHECK -> lives decrements, level unchanged, S_HIT entered.
- Mid-operation reset:
  - Assert reset during S_ERASE, and separately during S_HIT -> next edge S_IDLE, lives=2, level=0, erase=0, no update/respawn pulse.
